// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared definitions for the SRAM-backed FIFO controller.
//   ob_op_e         : output-buffer operation selected by {drain, load}
//   ob_op()         : builds the operation code from the load/drain strobes
//   room_after_pop(): true when the output buffer can accept one more
//                     in-flight read once this cycle's pop is accounted for
package sram_fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        OB_IDLE  = 2'b00,
        OB_LOAD  = 2'b01,
        OB_DRAIN = 2'b10,
        OB_SWAP  = 2'b11
    } ob_op_e;

    function automatic ob_op_e ob_op(input logic load, input logic drain);
        return ob_op_e'({drain, load});
    endfunction

    // Slots committed to the output buffer (held + read in flight - leaving)
    // must stay below two, otherwise the returning word has nowhere to land.
    function automatic logic room_after_pop(input logic [1:0] ob_cnt,
                                            input logic       rd_pend,
                                            input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, ob_cnt} + {2'b00, rd_pend} - {2'b00, pop};
        return (occ < 3'd2);
    endfunction

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry first-word-fall-through output buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of both entries
//   in_valid   : in_data is written at the tail this edge
//   m_ready    : consumer accepts m_data when m_valid
//   m_valid    : head entry is valid (registered)
//   m_data     : head entry (registered)
//   cnt        : entries held, 0..2
module sram_fifo_obuf
    import sram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            cnt
);

    logic [DATA_WIDTH-1:0] ob0_r, ob1_r, ob0_nxt, ob1_nxt;
    logic [1:0]            cnt_r, cnt_nxt;
    logic                  m_valid_r;
    logic                  pop_s;

    assign pop_s   = m_valid_r & m_ready;
    assign m_valid = m_valid_r;
    assign m_data  = ob0_r;
    assign cnt     = cnt_r;

    // Next-state for the two entries: shift on pop, write at tail on load.
    always_comb begin
        ob0_nxt = ob0_r;
        ob1_nxt = ob1_r;
        cnt_nxt = cnt_r;
        if (clr) begin
            ob0_nxt = {DATA_WIDTH{1'b0}};
            ob1_nxt = {DATA_WIDTH{1'b0}};
            cnt_nxt = 2'd0;
        end else begin
            case (ob_op(in_valid, pop_s))
                OB_LOAD: begin
                    if (cnt_r == 2'd0) begin
                        ob0_nxt = in_data;
                        cnt_nxt = 2'd1;
                    end else if (cnt_r == 2'd1) begin
                        ob1_nxt = in_data;
                        cnt_nxt = 2'd2;
                    end else begin
                        cnt_nxt = cnt_r;
                    end
                end
                OB_DRAIN: begin
                    ob0_nxt = ob1_r;
                    cnt_nxt = cnt_r - 2'd1;
                end
                // Pop and capture together: the tail moves up and the new
                // word lands behind it, occupancy unchanged.
                OB_SWAP: begin
                    if (cnt_r == 2'd1) begin
                        ob0_nxt = in_data;
                    end else begin
                        ob0_nxt = ob1_r;
                        ob1_nxt = in_data;
                    end
                end
                default: begin
                    cnt_nxt = cnt_r;
                end
            endcase
        end
    end

    // Entry and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob0_r     <= {DATA_WIDTH{1'b0}};
            ob1_r     <= {DATA_WIDTH{1'b0}};
            cnt_r     <= 2'd0;
            m_valid_r <= 1'b0;
        end else begin
            ob0_r     <= ob0_nxt;
            ob1_r     <= ob1_nxt;
            cnt_r     <= cnt_nxt;
            m_valid_r <= (cnt_nxt != 2'd0);
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Single-clock FIFO controller sequencing one dual-port SRAM as storage.
//   clk, rst_n, flush          : clock, async active-low reset, sync clear
//   s_valid/s_ready/s_data     : push side, drives the SRAM write port
//   m_valid/m_ready/m_data     : FWFT pop side, served by a 2-entry buffer
//   count, empty, full         : total words held (SRAM + in flight + buffer)
//   sram_rrst/sram_wrst        : SRAM port resets (~rst_n)
//   sram_rce/oe/raddr/dout     : SRAM read port, 1-cycle registered read
//   sram_wce/we/waddr/din      : SRAM write port
module sram_fifo_ctrl
    import sram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  empty,
    output logic                  full,
    output logic                  sram_rrst,
    output logic                  sram_wrst,
    output logic                  sram_rce,
    output logic                  sram_oe,
    output logic [ADDR_WIDTH-1:0] sram_raddr,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  sram_wce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_waddr,
    output logic [DATA_WIDTH-1:0] sram_din
);

    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt, rd_ptr_nxt;
    logic [ADDR_WIDTH:0] mem_cnt_s;
    logic                rd_pend_r, s_ready_r;
    logic                push_s, pop_s, issue_s;
    logic [1:0]          ob_cnt_s;
    logic                m_valid_s;

    // Words written but not yet read-issued; the wrap bits make the
    // difference span 0..DEPTH.
    assign mem_cnt_s = wr_ptr_r - rd_ptr_r;

    assign push_s  = s_valid & s_ready_r & ~flush;
    assign pop_s   = m_valid_s & m_ready;
    assign issue_s = ~flush & (mem_cnt_s != {(ADDR_WIDTH+1){1'b0}})
                   & room_after_pop(ob_cnt_s, rd_pend_r, pop_s);

    // SRAM ports. The read enable stays high during the capture cycle so the
    // read data remains driven. With nothing left to issue, rd_ptr equals
    // wr_ptr, so the held read points one slot back to stay off the slot
    // being written.
    assign sram_rrst  = ~rst_n;
    assign sram_wrst  = ~rst_n;
    assign sram_rce   = issue_s | rd_pend_r;
    assign sram_oe    = sram_rce;
    assign sram_raddr = (mem_cnt_s != {(ADDR_WIDTH+1){1'b0}})
                      ? rd_ptr_r[ADDR_WIDTH-1:0]
                      : rd_ptr_r[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
    assign sram_we    = push_s;
    assign sram_wce   = push_s;
    assign sram_waddr = wr_ptr_r[ADDR_WIDTH-1:0];
    assign sram_din   = s_data;

    assign s_ready = s_ready_r;
    assign full    = ~s_ready_r;
    assign m_valid = m_valid_s;
    assign count   = (ADDR_WIDTH+2)'(mem_cnt_s) + (ADDR_WIDTH+2)'(rd_pend_r)
                   + (ADDR_WIDTH+2)'(ob_cnt_s);
    assign empty   = (count == {(ADDR_WIDTH+2){1'b0}});

    // Pointer advance; flush returns both to zero.
    always_comb begin
        wr_ptr_nxt = wr_ptr_r;
        rd_ptr_nxt = rd_ptr_r;
        if (flush) begin
            wr_ptr_nxt = {(ADDR_WIDTH+1){1'b0}};
            rd_ptr_nxt = {(ADDR_WIDTH+1){1'b0}};
        end else begin
            wr_ptr_nxt = wr_ptr_r + (ADDR_WIDTH+1)'(push_s);
            rd_ptr_nxt = rd_ptr_r + (ADDR_WIDTH+1)'(issue_s);
        end
    end

    // Pointer, in-flight and push-ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r  <= {(ADDR_WIDTH+1){1'b0}};
            rd_ptr_r  <= {(ADDR_WIDTH+1){1'b0}};
            rd_pend_r <= 1'b0;
            s_ready_r <= 1'b0;
        end else begin
            wr_ptr_r  <= wr_ptr_nxt;
            rd_ptr_r  <= rd_ptr_nxt;
            rd_pend_r <= issue_s;
            s_ready_r <= ((wr_ptr_nxt - rd_ptr_nxt) < DEPTH_V);
        end
    end

    // Returning read data is dropped when a flush coincides with it.
    sram_fifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush),
        .in_valid (rd_pend_r & ~flush),
        .in_data  (sram_dout),
        .m_ready  (m_ready),
        .m_valid  (m_valid_s),
        .m_data   (m_data),
        .cnt      (ob_cnt_s)
    );

endmodule
